// File: rtl/cpu_mem_responder.sv
// Arbitrates the CPU instruction and data ports onto one memory port.
// Only one memory transaction is in flight, and every output comes from a register.
module cpu_mem_responder #(
    parameter int DMEM_PRIORITY = 0,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [1:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_byte_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        be;
        logic              write;
    } req_t;

    state_t            state, state_nxt;
    req_t              req_q, req_nxt;
    logic              last_dmem, last_dmem_nxt;
    logic              mem_read_nxt, mem_write_nxt;
    logic              imem_resp_nxt, dmem_resp_nxt;
    logic [DATA_W-1:0] imem_rdata_nxt, dmem_rdata_nxt;
    logic              dmem_req, grant_d;

    assign dmem_req = dmem_read | dmem_write;

    // Ties go to dmem under fixed priority, otherwise to whoever lost last time.
    always_comb begin
        grant_d = 1'b0;
        if (dmem_req && !imem_read)     grant_d = 1'b1;
        else if (dmem_req && imem_read) grant_d = (DMEM_PRIORITY != 0) ? 1'b1 : !last_dmem;
    end

    always_comb begin
        state_nxt      = state;
        req_nxt        = req_q;
        last_dmem_nxt  = last_dmem;
        mem_read_nxt   = mem_read;
        mem_write_nxt  = mem_write;
        imem_resp_nxt  = 1'b0;
        dmem_resp_nxt  = 1'b0;
        imem_rdata_nxt = imem_rdata;
        dmem_rdata_nxt = dmem_rdata;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = BUSY_D;
                    req_nxt.addr  = dmem_address;
                    req_nxt.wdata = dmem_wdata;
                    req_nxt.write = dmem_write;
                    // read+write together is a write; reads always fetch the whole word
                    req_nxt.be    = dmem_write ? dmem_byte_enable : 2'b11;
                    mem_write_nxt = dmem_write;
                    mem_read_nxt  = !dmem_write;
                end else if (imem_read) begin
                    state_nxt     = BUSY_I;
                    req_nxt.addr  = imem_address;
                    req_nxt.wdata = '0;
                    req_nxt.write = 1'b0;
                    req_nxt.be    = 2'b11;
                    mem_read_nxt  = 1'b1;
                end
            end
            BUSY_I: begin
                if (mem_resp) begin
                    state_nxt      = RESP_I;
                    mem_read_nxt   = 1'b0;
                    mem_write_nxt  = 1'b0;
                    imem_resp_nxt  = 1'b1;
                    imem_rdata_nxt = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    state_nxt     = RESP_D;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    dmem_resp_nxt = 1'b1;
                    if (!req_q.write) dmem_rdata_nxt = mem_rdata;
                end
            end
            RESP_I: begin
                state_nxt     = IDLE;
                last_dmem_nxt = 1'b0;
            end
            RESP_D: begin
                state_nxt     = IDLE;
                last_dmem_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            req_q      <= '0;
            last_dmem  <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            imem_resp  <= 1'b0;
            dmem_resp  <= 1'b0;
            imem_rdata <= '0;
            dmem_rdata <= '0;
        end else begin
            state      <= state_nxt;
            req_q      <= req_nxt;
            last_dmem  <= last_dmem_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            imem_resp  <= imem_resp_nxt;
            dmem_resp  <= dmem_resp_nxt;
            imem_rdata <= imem_rdata_nxt;
            dmem_rdata <= dmem_rdata_nxt;
        end
    end

    assign mem_address     = req_q.addr;
    assign mem_wdata       = req_q.wdata;
    assign mem_byte_enable = req_q.be;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: round-robin instance plus a fixed-priority instance.
module tb_cpu_mem_responder;
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } mem_txn_t;

    typedef struct {
        logic        port_d;
        logic [15:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    initial forever #5 clk = ~clk;

    // round-robin instance
    logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic [15:0] imem_address, imem_rdata, dmem_address, dmem_wdata, dmem_rdata;
    logic [1:0]  dmem_byte_enable, mem_byte_enable;
    logic        mem_read, mem_write, mem_resp, auto_resp, spur_resp;
    logic [15:0] mem_address, mem_wdata, mem_rdata;

    // fixed-priority instance
    logic        p_imem_read, p_imem_resp, p_dmem_read, p_dmem_write, p_dmem_resp;
    logic [15:0] p_imem_address, p_imem_rdata, p_dmem_address, p_dmem_rdata;
    logic [1:0]  p_mem_byte_enable;
    logic        p_mem_read, p_mem_write, p_mem_resp;
    logic [15:0] p_mem_address, p_mem_wdata, p_mem_rdata;

    assign mem_resp = auto_resp | spur_resp;

    cpu_mem_responder #(.DMEM_PRIORITY(0), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    cpu_mem_responder #(.DMEM_PRIORITY(1), .ADDR_W(16), .DATA_W(16)) dut_pri (
        .clk(clk), .reset(reset),
        .imem_read(p_imem_read), .imem_address(p_imem_address),
        .imem_rdata(p_imem_rdata), .imem_resp(p_imem_resp),
        .dmem_read(p_dmem_read), .dmem_write(p_dmem_write), .dmem_address(p_dmem_address),
        .dmem_wdata(16'h0000), .dmem_byte_enable(2'b00),
        .dmem_rdata(p_dmem_rdata), .dmem_resp(p_dmem_resp),
        .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_address(p_mem_address),
        .mem_wdata(p_mem_wdata), .mem_byte_enable(p_mem_byte_enable),
        .mem_rdata(p_mem_rdata), .mem_resp(p_mem_resp)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] exp_i[$];
    logic [15:0] exp_d[$];
    mem_txn_t    exp_mem[$];
    resp_t       p_exp[$];
    logic        mem_auto;
    int          mem_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_of(input logic [15:0] a);
        return (a == 16'h0040) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    // memory model: checks each strobe cycle against the expected transaction
    initial begin
        mem_txn_t cur;
        bit in_txn;
        int wcnt;
        in_txn = 0; wcnt = 0; auto_resp = 1'b0; mem_rdata = '0;
        cur = mem_txn_t'{1'b0, 16'h0, 16'h0, 2'b11};
        forever begin
            @(negedge clk);
            auto_resp = 1'b0;
            if (mem_auto && !reset && (mem_read || mem_write)) begin
                if (!in_txn) begin
                    in_txn = 1; wcnt = 0;
                    if (exp_mem.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mem_txn unexpected: addr %0h", mem_address);
                    end else cur = exp_mem.pop_front();
                end
                check("mem_write", mem_write, cur.wr);
                check("mem_read", mem_read, !cur.wr);
                check("mem_address", mem_address, cur.addr);
                check("mem_byte_enable", mem_byte_enable, cur.be);
                if (cur.wr) check("mem_wdata", mem_wdata, cur.wdata);
                if (wcnt == mem_wait) begin
                    auto_resp = 1'b1;
                    mem_rdata = cur.wr ? 16'hDEAD : rd_of(cur.addr);
                    in_txn = 0;
                end else wcnt++;
            end
        end
    end

    initial begin
        p_mem_resp = 1'b0; p_mem_rdata = '0;
        forever begin
            @(negedge clk);
            p_mem_resp  = (p_mem_read || p_mem_write) && !p_mem_resp;
            p_mem_rdata = p_mem_address ^ 16'h5A5A;
        end
    end

    // response monitors
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (imem_resp && dmem_resp) begin
                total++; bad++;
                $display("FAIL both_resp: imem and dmem resp together");
            end
            if (imem_resp) begin
                if (exp_i.size() == 0) begin
                    total++; bad++;
                    $display("FAIL imem_resp unexpected: rdata %0h", imem_rdata);
                end else begin
                    e = exp_i.pop_front();
                    check("imem_rdata", imem_rdata, e);
                end
            end
            if (dmem_resp) begin
                if (exp_d.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dmem_resp unexpected: rdata %0h", dmem_rdata);
                end else begin
                    e = exp_d.pop_front();
                    check("dmem_rdata", dmem_rdata, e);
                end
            end
        end
    end

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (p_imem_resp || p_dmem_resp) begin
                if (p_exp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pri_resp unexpected: i=%0b d=%0b", p_imem_resp, p_dmem_resp);
                end else begin
                    r = p_exp.pop_front();
                    check("pri_grant_port", p_dmem_resp, r.port_d);
                    check("pri_rdata", p_dmem_resp ? p_dmem_rdata : p_imem_rdata, r.data);
                end
            end
        end
    end

    task automatic drive_i(input logic [15:0] a);
        int n;
        imem_read = 1'b1; imem_address = a; n = 0;
        do begin @(negedge clk); n++; end while (!imem_resp && n < 100);
        if (!imem_resp) begin total++; bad++; $display("FAIL imem_timeout: addr %0h", a); end
        imem_read = 1'b0;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input logic [1:0] be);
        int n;
        dmem_read = rd; dmem_write = wr; dmem_address = a; dmem_wdata = wd;
        dmem_byte_enable = be; n = 0;
        do begin @(negedge clk); n++; end while (!dmem_resp && n < 100);
        if (!dmem_resp) begin total++; bad++; $display("FAIL dmem_timeout: addr %0h", a); end
        dmem_read = 1'b0; dmem_write = 1'b0;
    endtask

    task automatic p_drive_i(input logic [15:0] a);
        int n;
        p_imem_read = 1'b1; p_imem_address = a; n = 0;
        do begin @(negedge clk); n++; end while (!p_imem_resp && n < 100);
        if (!p_imem_resp) begin total++; bad++; $display("FAIL pri_imem_timeout: addr %0h", a); end
        p_imem_read = 1'b0;
    endtask

    task automatic p_drive_d(input logic [15:0] a);
        int n;
        p_dmem_read = 1'b1; p_dmem_address = a; n = 0;
        do begin @(negedge clk); n++; end while (!p_dmem_resp && n < 100);
        if (!p_dmem_resp) begin total++; bad++; $display("FAIL pri_dmem_timeout: addr %0h", a); end
        p_dmem_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_auto = 1'b1; mem_wait = 0; spur_resp = 1'b0;
        imem_read = 0; imem_address = 0; dmem_read = 0; dmem_write = 0;
        dmem_address = 0; dmem_wdata = 0; dmem_byte_enable = 0;
        p_imem_read = 0; p_imem_address = 0; p_dmem_read = 0; p_dmem_write = 0; p_dmem_address = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_imem_resp", imem_resp, 0);
        check("rst_dmem_resp", dmem_resp, 0);
        check("rst_imem_rdata", imem_rdata, 0);
        check("rst_dmem_rdata", dmem_rdata, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_byte_enable", mem_byte_enable, 0);

        // single imem read, two wait cycles
        mem_wait = 2;
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0040, 16'h0000, 2'b11});
        exp_i.push_back(16'h1234);
        drive_i(16'h0040);
        @(negedge clk);
        check("imem_resp_single_cycle", imem_resp, 0);

        // dmem write; dmem_rdata keeps its reset value
        mem_wait = 1;
        exp_mem.push_back(mem_txn_t'{1'b1, 16'h0102, 16'hBEEF, 2'b01});
        exp_d.push_back(16'h0000);
        drive_d(1'b0, 1'b1, 16'h0102, 16'hBEEF, 2'b01);
        @(negedge clk);
        check("dmem_resp_single_cycle", dmem_resp, 0);

        // continuous requests on both ports: imem, dmem, imem, dmem
        mem_wait = 0;
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0044, 16'h0000, 2'b11});
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0200, 16'h0000, 2'b11});
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0048, 16'h0000, 2'b11});
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0300, 16'h0000, 2'b11});
        exp_i.push_back(16'h5A1E); exp_i.push_back(16'h5A12);
        exp_d.push_back(16'h585A); exp_d.push_back(16'h595A);
        fork
            begin drive_i(16'h0044); drive_i(16'h0048); end
            begin drive_d(1'b1, 1'b0, 16'h0200, 16'h0, 2'b00);
                  drive_d(1'b1, 1'b0, 16'h0300, 16'h0, 2'b00); end
        join
        @(negedge clk);

        // read and write together act as a write; rdata holds the last read word
        mem_wait = 1;
        exp_mem.push_back(mem_txn_t'{1'b1, 16'h0104, 16'hCAFE, 2'b10});
        exp_d.push_back(16'h595A);
        drive_d(1'b1, 1'b1, 16'h0104, 16'hCAFE, 2'b10);
        @(negedge clk);

        // requester address changes while the memory is busy
        mem_wait = 2;
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0040, 16'h0000, 2'b11});
        exp_i.push_back(16'h1234);
        fork
            drive_i(16'h0040);
            begin repeat (2) @(negedge clk); imem_address = 16'h0050; end
        join
        @(negedge clk);

        // spurious mem_resp in IDLE
        mem_auto = 1'b0;
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("spur_imem_resp", imem_resp, 0);
            check("spur_dmem_resp", dmem_resp, 0);
            check("spur_mem_read", mem_read, 0);
        end

        // reset while a dmem write is outstanding
        dmem_write = 1'b1; dmem_address = 16'h0102; dmem_wdata = 16'hBEEF; dmem_byte_enable = 2'b01;
        repeat (2) @(negedge clk);
        check("busy_mem_write", mem_write, 1);
        check("busy_mem_address", mem_address, 16'h0102);
        check("busy_mem_wdata", mem_wdata, 16'hBEEF);
        check("busy_mem_byte_enable", mem_byte_enable, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        check("abort_mem_write", mem_write, 0);
        reset = 1'b0; dmem_write = 1'b0;
        spur_resp = 1'b1;
        @(negedge clk);
        spur_resp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("late_dmem_resp", dmem_resp, 0);
            check("late_mem_write", mem_write, 0);
        end
        mem_auto = 1'b1; mem_wait = 0;
        exp_mem.push_back(mem_txn_t'{1'b0, 16'h0048, 16'h0000, 2'b11});
        exp_i.push_back(16'h5A12);
        drive_i(16'h0048);
        @(negedge clk);

        // fixed priority: dmem served while it keeps requesting, then imem
        p_exp.push_back(resp_t'{1'b1, 16'h5A7A});
        p_exp.push_back(resp_t'{1'b1, 16'h5A78});
        p_exp.push_back(resp_t'{1'b0, 16'h5A4A});
        fork
            p_drive_i(16'h0010);
            begin p_drive_d(16'h0020); p_drive_d(16'h0022); end
        join
        repeat (3) @(negedge clk);

        check("drain_exp_i", exp_i.size(), 0);
        check("drain_exp_d", exp_d.size(), 0);
        check("drain_exp_mem", exp_mem.size(), 0);
        check("drain_pri", p_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
